// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: data-processing opcodes,
// shifter type codes and opcode classification helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
    OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
    OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
    OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
  } op_e;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  // Ops whose C/V come from the adder rather than the shifter.
  function automatic logic is_arith(input op_e op);
    return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  endfunction

  // Flag-only ops: result is produced but not written back.
  function automatic logic is_test(input op_e op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational ARM-style operand-2 shifter.
// Ports: b (operand), shift_op (LSL/LSR/ASR/ROR/RRX, 5-7 pass), shift_num
// (0..255), cin (carry in) -> value (shifted operand), sc (shifter carry).
module barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       shift_op,
  input  logic [7:0]       shift_num,
  input  logic             cin,
  output logic [WIDTH-1:0] value,
  output logic             sc
);

  localparam int LW = $clog2(WIDTH);

  // One extra bit on the side the bits leave from catches the last bit
  // shifted out, which is the shifter carry for every n>0 including n=W
  // and n>W (where the shift empties the vector and the carry becomes 0).
  logic [WIDTH:0]        lsl_x, lsr_x, asr_x;
  logic signed [WIDTH:0] sgn;
  logic [WIDTH-1:0]      ror_v;
  logic [LW-1:0]         rot;

  always_comb begin
    lsl_x = {1'b0, b} << shift_num;
    lsr_x = {b, 1'b0} >> shift_num;
    sgn   = {b, 1'b0};
    asr_x = sgn >>> shift_num;
    rot   = LW'(shift_num);  // rotate amount is n mod W
    ror_v = (b >> rot) | (b << (WIDTH - int'(rot)));

    value = b;
    sc    = cin;
    if (shift_op == SH_RRX) begin
      value = {cin, b[WIDTH-1:1]};
      sc    = b[0];
    end else if (shift_num != 8'd0) begin
      case (shift_op)
        SH_LSL: begin value = lsl_x[WIDTH-1:0]; sc = lsl_x[WIDTH]; end
        SH_LSR: begin value = lsr_x[WIDTH:1];   sc = lsr_x[0];     end
        SH_ASR: begin value = asr_x[WIDTH:1];   sc = asr_x[0];     end
        SH_ROR: begin value = ror_v;            sc = ror_v[WIDTH-1]; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ARM data-processing ALU with valid/ready on both sides.
// Stage 1 registers the shifted operand; stage 2 computes the result into
// the output register and updates the registered NZCV flags.
// Ports: CP/reset (async, active-high); in_valid/in_ready, a, b, op, cin,
// shift_op, shift_num, set_flags, tag_in (request); out_valid/out_ready,
// out, out_wr, tag_out (result); nout/zout/cout/vout (flags).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             CP,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic [2:0]       shift_op,
  input  logic [7:0]       shift_num,
  input  logic             set_flags,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_wr,
  output logic [TAG_W-1:0] tag_out,
  output logic             nout,
  output logic             zout,
  output logic             cout,
  output logic             vout
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] s;
    logic             sc;
    logic             cin;
    logic             set_flags;
    op_e              op;
    logic [TAG_W-1:0] tag;
  } s1_t;

  s1_t              s1;
  logic             s1_valid;
  logic [WIDTH-1:0] sh_value;
  logic             sh_c;
  logic             s2_free, accept, s2_load;

  barrel_shifter #(.WIDTH(WIDTH)) u_shift (
    .b(b), .shift_op(shift_op), .shift_num(shift_num), .cin(cin),
    .value(sh_value), .sc(sh_c)
  );

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;

  // Stage 1 payload needs no reset; s1_valid qualifies it.
  always_ff @(posedge CP) begin
    if (accept)
      s1 <= '{a: a, s: sh_value, sc: sh_c, cin: cin, set_flags: set_flags,
              op: op_e'(op), tag: tag_in};
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset)        s1_valid <= 1'b0;
    else if (accept)  s1_valid <= 1'b1;
    else if (s2_load) s1_valid <= 1'b0;
  end

  // Stage 2: operand swap/invert feeds one W+1-bit adder for all arith ops.
  logic [WIDTH-1:0] x, y, res;
  logic [WIDTH:0]   sum;
  logic             ci, c_nxt, v_nxt;

  always_comb begin
    x  = s1.a;
    y  = s1.s;
    ci = 1'b0;
    case (s1.op)
      OP_SUB, OP_CMP: begin y = ~s1.s; ci = 1'b1; end
      OP_RSB:         begin x = s1.s; y = ~s1.a; ci = 1'b1; end
      OP_ADC:         ci = s1.cin;
      OP_SBC:         begin y = ~s1.s; ci = s1.cin; end
      OP_RSC:         begin x = s1.s; y = ~s1.a; ci = s1.cin; end
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

    case (s1.op)
      OP_AND, OP_TST: res = s1.a & s1.s;
      OP_EOR, OP_TEQ: res = s1.a ^ s1.s;
      OP_ORR:         res = s1.a | s1.s;
      OP_MOV:         res = s1.s;
      OP_BIC:         res = s1.a & ~s1.s;
      OP_MVN:         res = ~s1.s;
      default:        res = sum[WIDTH-1:0];
    endcase

    if (is_arith(s1.op)) begin
      c_nxt = sum[WIDTH];
      v_nxt = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else begin
      c_nxt = s1.sc;
      v_nxt = vout;
    end
  end

  always_ff @(posedge CP or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_wr    <= 1'b0;
      tag_out   <= '0;
      {nout, zout, cout, vout} <= 4'b0000;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out       <= res;
      out_wr    <= !is_test(s1.op);
      tag_out   <= s1.tag;
      if (s1.set_flags)
        {nout, zout, cout, vout} <= {res[WIDTH-1], res == '0, c_nxt, v_nxt};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the stimulus side computes expectations
// from an arithmetic reference model at accept time; a monitor pops and
// compares on every output transfer and checks stability while stalled.
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          CP = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, cin, set_flags, out_valid, out_ready, out_wr;
  logic [W-1:0]  a, b, out;
  logic [3:0]    op;
  logic [2:0]    shift_op;
  logic [7:0]    shift_num;
  logic [TW-1:0] tag_in, tag_out;
  logic          nout, zout, cout, vout;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .CP(CP), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .shift_op(shift_op), .shift_num(shift_num),
    .set_flags(set_flags), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_wr(out_wr), .tag_out(tag_out),
    .nout(nout), .zout(zout), .cout(cout), .vout(vout)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [31:0] out;
    logic        wr;
    logic [3:0]  tag;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0, failures = 0, n_acc = 0;
  logic [3:0] mflags = 4'b0000;
  bit         rdone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: shift table and flag rules evaluated with plain
  // integer arithmetic (borrow/overflow from range checks).
  task automatic model(input logic [31:0] ia, ib, input logic [3:0] iop,
                       input logic icin, input logic [2:0] ish, input logic [7:0] inum,
                       input logic isf, input logic [3:0] itag, output exp_t e);
    logic [31:0]        v, res;
    logic signed [31:0] sb;
    logic               sc, c, vf;
    int                 k, bw;
    longint             ua, us, u, sa, ss, sr;
    k = int'(inum);
    sb = ib;
    v = ib; sc = icin;
    case (ish)
      3'd0: if (k > 0 && k < 32) begin v = ib << k; sc = ib[32-k]; end
            else if (k == 32) begin v = 0; sc = ib[0]; end
            else if (k > 32) begin v = 0; sc = 1'b0; end
      3'd1: if (k > 0 && k < 32) begin v = ib >> k; sc = ib[k-1]; end
            else if (k == 32) begin v = 0; sc = ib[31]; end
            else if (k > 32) begin v = 0; sc = 1'b0; end
      3'd2: if (k > 0 && k < 32) begin v = sb >>> k; sc = ib[k-1]; end
            else if (k >= 32) begin v = {32{ib[31]}}; sc = ib[31]; end
      3'd3: if (k > 0) begin
              repeat (k % 32) v = {v[0], v[31:1]};
              sc = v[31];
            end
      3'd4: begin v = {icin, ib[31:1]}; sc = ib[0]; end
      default: ;
    endcase
    ua = longint'(ia); us = longint'(v);
    sa = longint'($signed(ia)); ss = longint'($signed(v));
    bw = icin ? 0 : 1;
    u = 0; sr = 0; c = sc; vf = mflags[0];
    case (iop)
      4'd2, 4'd10: begin u = ua - us; c = (ua >= us); sr = sa - ss; end
      4'd3:        begin u = us - ua; c = (us >= ua); sr = ss - sa; end
      4'd4, 4'd11: begin u = ua + us; c = (u > 64'hFFFFFFFF); sr = sa + ss; end
      4'd5:        begin u = ua + us + icin; c = (u > 64'hFFFFFFFF); sr = sa + ss + icin; end
      4'd6:        begin u = ua - us - bw; c = (ua >= us + bw); sr = sa - ss - bw; end
      4'd7:        begin u = us - ua - bw; c = (us >= ua + bw); sr = ss - sa - bw; end
      default: ;
    endcase
    case (iop)
      4'd0, 4'd8:  res = ia & v;
      4'd1, 4'd9:  res = ia ^ v;
      4'd12:       res = ia | v;
      4'd13:       res = v;
      4'd14:       res = ia & ~v;
      4'd15:       res = ~v;
      default: begin
        res = u[31:0];
        vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
    endcase
    if (isf) mflags = {res[31], res == 32'd0, c, vf};
    e.out  = res;
    e.wr   = !(iop inside {[4'd8:4'd11]});
    e.tag  = itag;
    e.nzcv = mflags;
  endtask

  task automatic send(input logic [31:0] ia, ib, input logic [3:0] iop, input logic icin,
                      input logic [2:0] ish, input logic [7:0] inum, input logic isf,
                      input logic [3:0] itag);
    exp_t e;
    bit   got = 0;
    @(negedge CP);
    a = ia; b = ib; op = iop; cin = icin; shift_op = ish; shift_num = inum;
    set_flags = isf; tag_in = itag; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (in_ready) begin
        model(ia, ib, iop, icin, ish, inum, isf, itag, e);
        exp_q.push_back(e);
        n_acc++;
        got = 1;
        @(posedge CP);
        #1 in_valid = 1'b0;
      end else begin
        @(negedge CP);
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", itag);
      in_valid = 1'b0;
    end
  endtask

  // Replace the expectation of the request just accepted by hand-derived constants.
  task automatic expect_last(input logic [31:0] o, input logic wr, input logic [3:0] nzcv);
    exp_t e;
    e = exp_q.pop_back();
    e.out = o; e.wr = wr; e.nzcv = nzcv;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CP); #3;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  // Monitor
  initial begin
    exp_t e, prev;
    bit   have_prev = 0;
    forever begin
      @(negedge CP); #2;
      if (reset) begin
        have_prev = 0;
      end else begin
        if (have_prev) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_out", out, prev.out);
          chk("stall_tag", 32'(tag_out), 32'(prev.tag));
          chk("stall_flags", 32'({nout, zout, cout, vout}), 32'(prev.nzcv));
        end
        have_prev = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out: got %h tag %0d expected nothing", out, tag_out);
          end else begin
            e = exp_q.pop_front();
            chk("out", out, e.out);
            chk("out_wr", 32'(out_wr), 32'(e.wr));
            chk("tag_out", 32'(tag_out), 32'(e.tag));
            chk("flags", 32'({nout, zout, cout, vout}), 32'(e.nzcv));
          end
        end else if (out_valid) begin
          prev.out = out; prev.wr = out_wr; prev.tag = tag_out;
          prev.nzcv = {nout, zout, cout, vout};
          have_prev = 1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  rn;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    shift_op = '0; shift_num = '0; set_flags = 1'b0; tag_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge CP);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({nout, zout, cout, vout}), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    @(negedge CP) reset = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD wrap to zero, with latency probe
    send(32'hFFFFFFFF, 32'd1, 4'd4, 1'b0, 3'd0, 8'd0, 1'b1, 4'd1);
    expect_last(32'h0, 1'b1, 4'b0110);
    chk("lat_after_accept", 32'(out_valid), 32'd0);
    @(posedge CP); #1 chk("lat_next_edge", 32'(out_valid), 32'd1);
    drain();

    // CMP overflow, then EOR keeps V, then ADD without flag update
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 4'd10, 1'b0, 3'd0, 8'd0, 1'b1, 4'd2);
    expect_last(32'h80000000, 1'b0, 4'b1001);
    send(32'hF0F0F0F0, 32'h0F0F0F0F, 4'd1, 1'b1, 3'd0, 8'd0, 1'b1, 4'd3);
    expect_last(32'hFFFFFFFF, 1'b1, 4'b1011);
    send(32'd1, 32'd1, 4'd4, 1'b0, 3'd0, 8'd0, 1'b0, 4'd4);
    expect_last(32'd2, 1'b1, 4'b1011);
    drain();

    // MOV shifter boundaries
    send(32'd0, 32'h80000001, 4'd13, 1'b0, 3'd3, 8'd1, 1'b1, 4'd5);
    expect_last(32'hC0000000, 1'b1, 4'b1011);
    send(32'd0, 32'h80000001, 4'd13, 1'b0, 3'd1, 8'd32, 1'b1, 4'd6);
    expect_last(32'h0, 1'b1, 4'b0111);
    send(32'd0, 32'h80000001, 4'd13, 1'b0, 3'd0, 8'd40, 1'b1, 4'd7);
    expect_last(32'h0, 1'b1, 4'b0101);
    send(32'd0, 32'h80000001, 4'd13, 1'b0, 3'd4, 8'd0, 1'b1, 4'd8);
    expect_last(32'h40000000, 1'b1, 4'b0011);
    drain();

    // Backpressure: 5 back-to-back ADDs with the consumer stalled
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int t = 0; t < 5; t++) send($urandom, $urandom, 4'd4, 1'b0, 3'd0, 8'd0, 1'b0, 4'(t));
      end
      begin
        repeat (3) @(negedge CP);
        #2;
        chk("bp_accepts", 32'(n_acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(negedge CP) out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two requests in flight
    out_ready = 1'b0;
    send($urandom, $urandom, 4'd4, 1'b0, 3'd0, 8'd0, 1'b1, 4'd9);
    send($urandom, $urandom, 4'd2, 1'b1, 3'd0, 8'd0, 1'b1, 4'd10);
    @(negedge CP);
    reset = 1'b1;
    exp_q.delete();
    mflags = 4'b0000;
    #1;
    chk("rst_fly_valid", 32'(out_valid), 32'd0);
    chk("rst_fly_flags", 32'({nout, zout, cout, vout}), 32'd0);
    @(negedge CP) reset = 1'b0;
    #1 chk("rst_fly_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(32'd5, 32'd3, 4'd2, 1'b0, 3'd0, 8'd0, 1'b1, 4'd11);
    expect_last(32'd2, 1'b1, 4'b0010);
    drain();

    // Randomized traffic with random backpressure
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          ra = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
          rb = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
          case ($urandom_range(0, 7))
            0: rn = 8'd0;  1: rn = 8'd31; 2: rn = 8'd32; 3: rn = 8'd33;
            4: rn = 8'($urandom_range(0, 255));
            default: rn = 8'($urandom_range(0, 40));
          endcase
          send(ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), rn, 1'($urandom_range(0, 1)), 4'(i));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(negedge CP);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
